botoes_autorepeat: RTL

//  - Parametrised successor to the fixed 4-key repeat-pulse logic: N active-low push-buttons in, one-cycle

---
 rtl/botoes_pkg.sv | 19 +
 rtl/botoes_canal.sv | 104 ++++++++++
 rtl/botoes_autorepeat.sv | 35 +++
 3 files changed

// File: rtl/botoes_pkg.sv
// Shared state encoding and default 50 MHz timing for the push-button auto-repeat block.
package botoes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYC = 500_000;     // 10 ms
    localparam int DEF_DELAY_CYC    = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_CYC   = 12_500_000;  // 250 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/botoes_canal.sv
// One key channel: 2-flop synchroniser, debounce filter, and the press/auto-repeat FSM with its timer.
module botoes_canal
    import botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int DELAY_CYC    = DEF_DELAY_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk_50,
    input  logic reset,
    input  logic key,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam int   DW       = $clog2(DEBOUNCE_CYC + 1);
    localparam int   TW       = $clog2(max_int(DELAY_CYC, REPEAT_CYC) + 1);
    localparam logic RELEASED = ACTIVE_LOW;

    logic          sync_1, sync_2, s;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic          accept, rise, delay_hit, repeat_hit, pulse_d;
    state_t        state, next_state;

    always_ff @(posedge clk_50) begin
        // NOTE: non-blocking so each flop samples its pre-edge input; blocking would merge the two stages.
        if (reset) begin
            sync_1 <= RELEASED;
            sync_2 <= RELEASED;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
        end
    end

    assign s      = ACTIVE_LOW ? ~sync_2 : sync_2;
    assign accept = (s != held) && (dcnt == DW'(DEBOUNCE_CYC - 1));
    assign rise   = accept && s;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            held <= 1'b0;
            dcnt <= '0;
        end else if (s == held) begin
            dcnt <= '0;
        end else if (accept) begin
            held <= s;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    assign delay_hit  = (state == DELAY)  && (tcnt == TW'(DELAY_CYC - 1));
    assign repeat_hit = (state == REPEAT) && (tcnt == TW'(REPEAT_CYC - 1));

    // The press pulse is registered alongside held, so both rise on the same edge.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state <= IDLE;
            pulse <= 1'b0;
        end else begin
            state <= next_state;
            pulse <= pulse_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state; a missing branch would infer a latch.
        next_state = state;
        if (rise) begin
            next_state = DELAY;
        end else if (!held) begin
            next_state = IDLE;
        end else begin
            case (state)
                DELAY:   if (!repeat_en) next_state = HOLD; else if (delay_hit) next_state = REPEAT;
                REPEAT:  if (!repeat_en) next_state = HOLD;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        pulse_d = rise || (held && repeat_en && (delay_hit || repeat_hit));
    end

    // Timer restarts on every state change and on each repeat; it idles at zero outside DELAY/REPEAT.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            tcnt <= '0;
        end else if (next_state != state || repeat_hit) begin
            tcnt <= '0;
        end else if (state == DELAY || state == REPEAT) begin
            tcnt <= tcnt + TW'(1);
        end else begin
            tcnt <= '0;
        end
    end

endmodule

// File: rtl/botoes_autorepeat.sv
// N independent debounced push-button channels producing one-cycle press and auto-repeat strobes.
module botoes_autorepeat
    import botoes_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int DELAY_CYC    = DEF_DELAY_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] pulse,
    output logic [N_KEYS-1:0] held
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_canal
        botoes_canal #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .DELAY_CYC    (DELAY_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_canal (
            .clk_50    (clk_50),
            .reset     (reset),
            .key       (key[i]),
            .repeat_en (repeat_en),
            .pulse     (pulse[i]),
            .held      (held[i])
        );
    end

endmodule
